text_display_engine: RTL and testbench
======================================

TEXT_DISPLAY_ENGINE -- requirements
Module: text_display_engine

Interface
REQ-001 The module SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 The module SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48: horizontal porch and sync widths, in pixels.
REQ-003 The module SHALL have parameter V_ACTIVE, default 480, and parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, in lines.
REQ-004 The module SHALL have parameter FONT_H, default 8: font rows per glyph, legal values 8 or 16; COLS=H_ACTIVE/8, ROWS=V_ACTIVE/FONT_H.
REQ-005 The module SHALL have parameter VRAM_AW, default 15, and parameter VRAM_BASE, default 15'h3000: text buffer word address.
REQ-006 The module SHALL have parameters BLINK_FRAMES, default 30, and SYNC_POL, default 0: 0 = active-low syncs.
REQ-007 The module SHALL have ports clk (in, 1, sole clock) and rst (in, 1, synchronous active-high reset).
REQ-008 The module SHALL have port pix_ce (in, 1): pixel-advance enable, never high on two consecutive clocks.
REQ-009 The module SHALL have ports vram_addr (out, VRAM_AW) and vram_data (in, 32): synchronous text RAM, 1-clock read latency.
REQ-010 The module SHALL have ports font_addr (out, 8+log2(FONT_H), {ascii,row}) and font_data (in, 8): synchronous font ROM, 1-clock read latency.
REQ-011 The module SHALL have ports pal_we (in, 1), pal_idx (in, 4) and pal_data (in, 8): palette write port.
REQ-012 The module SHALL have ports scroll_row (in, 6), cursor_en (in, 1), cursor_col (in, 7) and cursor_row (in, 6).
REQ-013 The module SHALL have outputs rgb (8, RGB332), hsync (1), vsync (1), vblank (1) and frame_pulse (1).

Function
REQ-014 hc SHALL increment on pix_ce and wrap to 0 after H_ACTIVE+H_FP+H_SYNC+H_BP-1; vc SHALL increment on each hc wrap and wrap after the vertical total minus 1.
REQ-015 Pixel (hc,vc) SHALL be visible iff hc<H_ACTIVE and vc<V_ACTIVE; col=hc/8, screen row=vc/FONT_H, glyph line=vc%FONT_H.
REQ-016 Word fetched SHALL be VRAM_BASE + ((row+scroll_row) mod ROWS)*COLS/2 + col/2; the wrap SHALL use modulo ROWS, not modulo 64.
REQ-017 Each word SHALL hold two cells {attr[7:0],ascii[7:0]}: even col in [31:16], odd col in [15:0].
REQ-018 Pipeline stage A (pix_ce at hc,vc) SHALL register vram_addr.
REQ-019 Stage B (next pix_ce) SHALL capture the cell, register font_addr={ascii,glyph line}, and hold attr.
REQ-020 Stage C (next pix_ce) SHALL register rgb; the pixel bit SHALL be font_data[hc%8], bit 0 leftmost.
REQ-021 rgb SHALL be pal[attr[3:0]] when the bit is 1, pal[attr[7:4]] when 0, and 8'h00 when not visible.
REQ-022 hsync, vsync and the visible flag SHALL be delayed through the same 3 pix_ce stages, so rgb/hsync/vsync stay aligned.
REQ-023 hsync SHALL be active for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync SHALL follow the same rule on vc; active level = SYNC_POL.
REQ-024 vblank SHALL be undelayed: 1 iff vc>=V_ACTIVE.
REQ-025 frame_pulse SHALL be high for exactly one clk, on the pix_ce on which the counters wrap to (0,0).
REQ-026 The blink counter SHALL count frame_pulse events and toggle blink phase after BLINK_FRAMES of them, then restart from 0.
REQ-027 Cursor: when cursor_en, blink phase=1, the screen cell matches (cursor_col,cursor_row) and glyph line>=FONT_H-2, the pixel bit SHALL be forced to 1.
REQ-028 cursor_col>=COLS or cursor_row>=ROWS SHALL display no cursor.
REQ-029 A palette write SHALL take effect on the clock after pal_we; a stage C lookup of the same index on that same clock SHALL use the old value.
REQ-030 scroll_row, cursor_* and palette changes SHALL be accepted at any time without corrupting sync timing.
REQ-031 Between pix_ce pulses, all state and outputs except frame_pulse deassertion SHALL hold.

Reset
REQ-032 On rst, hc, vc, pipeline valid flags, blink counter and blink phase SHALL be cleared to 0.
REQ-033 On rst, rgb=8'h00, hsync=vsync=~SYNC_POL, vblank=0 and frame_pulse=0.
REQ-034 On rst, palette entries 0-14 SHALL be 8'h00 and entry 15 SHALL be 8'hFF.
REQ-035 rst asserted mid-frame SHALL restart timing at (0,0) on the next pix_ce, with no partial-stage data emitted.

Verification
REQ-036 Defaults, pix_ce every 2nd clk, count clocks between frame_pulse -> 800*525*2 = 840000.
REQ-037 Word at 15'h3000 = 32'h0F41_0F42, font 'A' line0 = 8'h01 -> rgb at pixel(0,0) = 8'hFF 3 pix_ce after counter (0,0), pixel(1,0) = 8'h00.
REQ-038 scroll_row=59, ROWS=60 -> screen row 0 fetches 15'h3000+59*40, screen row 1 fetches 15'h3000.
REQ-039 cursor_en=1, cursor at (5,2), FONT_H=8 -> frames 0-29 show no cursor; frames 30-59 show fg on lines 22-23, cols 40-47.
REQ-040 pal_we idx 15 = 8'hE0 during an active line -> following pixels read 8'hE0; rst mid-frame -> rgb 8'h00, syncs inactive, restart at (0,0).

Source files
------------

// File: rtl/text_display_engine.sv
`default_nettype none
// ============================================================================
// Module   : text_display_engine
// Brief    : Character-cell text display with raster timing, a 3-stage fetch
//            pipeline, a 16-entry RGB332 palette, scrolling and blinking cursor.
// Revision : 1.0 - initial release
// ============================================================================
module text_display_engine #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int FONT_H       = 8,
    parameter int VRAM_AW      = 15,
    parameter int VRAM_BASE    = 15'h3000,
    parameter int BLINK_FRAMES = 30,
    parameter bit SYNC_POL     = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pix_ce,
    output logic [VRAM_AW-1:0]          vram_addr,
    input  logic [31:0]                 vram_data,
    output logic [8+$clog2(FONT_H)-1:0] font_addr,
    input  logic [7:0]                  font_data,
    input  logic                        pal_we,
    input  logic [3:0]                  pal_idx,
    input  logic [7:0]                  pal_data,
    input  logic [5:0]                  scroll_row,
    input  logic                        cursor_en,
    input  logic [6:0]                  cursor_col,
    input  logic [5:0]                  cursor_row,
    output logic [7:0]                  rgb,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        vblank,
    output logic                        frame_pulse
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_COLS    = H_ACTIVE / 8;
    localparam int c_ROWS    = V_ACTIVE / FONT_H;
    localparam int c_LW      = $clog2(FONT_H);
    localparam int c_HW      = $clog2(c_H_TOTAL);
    localparam int c_VW      = $clog2(c_V_TOTAL);
    localparam int c_BW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // raster counters and blink state
    logic [c_HW-1:0]    r_hc;
    logic [c_VW-1:0]    r_vc;
    logic [c_BW-1:0]    r_blink_cnt;
    logic               r_blink;
    logic               r_frame_pulse;

    // stage A: address issued, pixel attributes carried forward
    logic [VRAM_AW-1:0] r_vram_addr;
    logic               r_a_valid;
    logic               r_a_vis;
    logic               r_a_hs;
    logic               r_a_vs;
    logic               r_a_odd;
    logic               r_a_cur;
    logic [2:0]         r_a_px;
    logic [c_LW-1:0]    r_a_line;

    // stage B: cell captured, glyph row requested
    logic [8+c_LW-1:0]  r_font_addr;
    logic [7:0]         r_b_attr;
    logic               r_b_valid;
    logic               r_b_vis;
    logic               r_b_hs;
    logic               r_b_vs;
    logic               r_b_cur;
    logic [2:0]         r_b_px;

    // stage C: final pixel
    logic [7:0]         r_rgb;
    logic               r_hsync;
    logic               r_vsync;

    logic [7:0]         r_pal [16];

    logic [31:0]        w_hc32;
    logic [31:0]        w_vc32;
    logic [31:0]        w_col;
    logic [31:0]        w_row;
    logic [31:0]        w_srow;
    logic [31:0]        w_line32;
    logic               w_h_last;
    logic               w_v_last;
    logic               w_wrap;
    logic               w_vis;
    logic               w_hs_act;
    logic               w_vs_act;
    logic               w_cur_hit;
    logic [15:0]        w_cell;
    logic               w_bit;
    logic [7:0]         w_color;

    always_comb begin
        w_hc32    = 32'(r_hc);
        w_vc32    = 32'(r_vc);
        w_line32  = 32'(r_vc[c_LW-1:0]);
        w_col     = w_hc32 >> 3;
        w_row     = w_vc32 >> c_LW;
        // wrap on the real row count so scrolling never lands outside the buffer
        w_srow    = (w_row + 32'(scroll_row)) % c_ROWS;
        w_h_last  = (w_hc32 == 32'(c_H_TOTAL - 1));
        w_v_last  = (w_vc32 == 32'(c_V_TOTAL - 1));
        w_wrap    = pix_ce && w_h_last && w_v_last;
        w_vis     = (w_hc32 < 32'(H_ACTIVE)) && (w_vc32 < 32'(V_ACTIVE));
        w_hs_act  = (w_hc32 >= 32'(H_ACTIVE + H_FP)) &&
                    (w_hc32 <  32'(H_ACTIVE + H_FP + H_SYNC));
        w_vs_act  = (w_vc32 >= 32'(V_ACTIVE + V_FP)) &&
                    (w_vc32 <  32'(V_ACTIVE + V_FP + V_SYNC));
        w_cur_hit = cursor_en && r_blink &&
                    (32'(cursor_col) < 32'(c_COLS)) && (32'(cursor_row) < 32'(c_ROWS)) &&
                    (w_col == 32'(cursor_col)) && (w_row == 32'(cursor_row)) &&
                    (w_line32 >= 32'(FONT_H - 2));
        w_cell    = r_a_odd ? vram_data[15:0] : vram_data[31:16];
        w_bit     = font_data[r_b_px] | r_b_cur;
        w_color   = w_bit ? r_pal[r_b_attr[3:0]] : r_pal[r_b_attr[7:4]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hc          <= '0;
            r_vc          <= '0;
            r_blink_cnt   <= '0;
            r_blink       <= 1'b0;
            r_frame_pulse <= 1'b0;
        end else begin
            r_frame_pulse <= w_wrap;
            if (pix_ce) begin
                if (w_h_last) begin
                    r_hc <= '0;
                    r_vc <= w_v_last ? '0 : r_vc + c_VW'(1);
                end else begin
                    r_hc <= r_hc + c_HW'(1);
                end
            end
            if (w_wrap) begin
                if (r_blink_cnt == c_BW'(BLINK_FRAMES - 1)) begin
                    r_blink_cnt <= '0;
                    r_blink     <= ~r_blink;
                end else begin
                    r_blink_cnt <= r_blink_cnt + c_BW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vram_addr <= '0;
            r_a_valid   <= 1'b0;
            r_a_vis     <= 1'b0;
            r_a_hs      <= 1'b0;
            r_a_vs      <= 1'b0;
            r_a_odd     <= 1'b0;
            r_a_cur     <= 1'b0;
            r_a_px      <= '0;
            r_a_line    <= '0;
            r_font_addr <= '0;
            r_b_attr    <= '0;
            r_b_valid   <= 1'b0;
            r_b_vis     <= 1'b0;
            r_b_hs      <= 1'b0;
            r_b_vs      <= 1'b0;
            r_b_cur     <= 1'b0;
            r_b_px      <= '0;
            r_rgb       <= 8'h00;
            r_hsync     <= ~SYNC_POL;
            r_vsync     <= ~SYNC_POL;
        end else if (pix_ce) begin
            r_vram_addr <= VRAM_AW'(32'(VRAM_BASE) + w_srow * 32'(c_COLS / 2) + (w_col >> 1));
            r_a_valid   <= 1'b1;
            r_a_vis     <= w_vis;
            r_a_hs      <= w_hs_act;
            r_a_vs      <= w_vs_act;
            r_a_odd     <= r_hc[3];
            r_a_cur     <= w_cur_hit;
            r_a_px      <= r_hc[2:0];
            r_a_line    <= r_vc[c_LW-1:0];

            r_font_addr <= {w_cell[7:0], r_a_line};
            r_b_attr    <= w_cell[15:8];
            r_b_valid   <= r_a_valid;
            r_b_vis     <= r_a_vis;
            r_b_hs      <= r_a_hs;
            r_b_vs      <= r_a_vs;
            r_b_cur     <= r_a_cur;
            r_b_px      <= r_a_px;

            // until the pipe has filled after reset, emit blank with idle syncs
            if (r_b_valid) begin
                r_rgb   <= r_b_vis ? w_color : 8'h00;
                r_hsync <= r_b_hs ? SYNC_POL : ~SYNC_POL;
                r_vsync <= r_b_vs ? SYNC_POL : ~SYNC_POL;
            end else begin
                r_rgb   <= 8'h00;
                r_hsync <= ~SYNC_POL;
                r_vsync <= ~SYNC_POL;
            end
        end
    end

    // palette writes land at the edge, so a same-edge lookup still sees the old entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_pal[i] <= (i == 15) ? 8'hFF : 8'h00;
            end
        end else if (pal_we) begin
            r_pal[pal_idx] <= pal_data;
        end
    end

    assign vram_addr   = r_vram_addr;
    assign font_addr   = r_font_addr;
    assign rgb         = r_rgb;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign vblank      = (w_vc32 >= 32'(V_ACTIVE));
    assign frame_pulse = r_frame_pulse;

endmodule
`default_nettype wire

// File: tb/tb_text_display_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_display_engine
// Brief    : Directed self-checking bench on a reduced 40x36 raster, 4x4 cells.
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_display_engine;

    localparam int c_H_ACTIVE = 32;
    localparam int c_V_ACTIVE = 32;
    localparam int c_FONT_H   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_ce;
    logic [14:0] vram_addr;
    logic [31:0] vram_data;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic        pal_we;
    logic [3:0]  pal_idx;
    logic [7:0]  pal_data;
    logic [5:0]  scroll_row;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic [7:0]  rgb;
    logic        hsync;
    logic        vsync;
    logic        vblank;
    logic        frame_pulse;

    int n_checks = 0;
    int n_err    = 0;
    int cnt      = 0;

    text_display_engine #(
        .H_ACTIVE     (c_H_ACTIVE),
        .H_FP         (2),
        .H_SYNC       (4),
        .H_BP         (2),
        .V_ACTIVE     (c_V_ACTIVE),
        .V_FP         (1),
        .V_SYNC       (2),
        .V_BP         (1),
        .FONT_H       (c_FONT_H),
        .VRAM_AW      (15),
        .VRAM_BASE    (15'h3000),
        .BLINK_FRAMES (2),
        .SYNC_POL     (1'b0)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .pix_ce      (pix_ce),
        .vram_addr   (vram_addr),
        .vram_data   (vram_data),
        .font_addr   (font_addr),
        .font_data   (font_data),
        .pal_we      (pal_we),
        .pal_idx     (pal_idx),
        .pal_data    (pal_data),
        .scroll_row  (scroll_row),
        .cursor_en   (cursor_en),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row),
        .rgb         (rgb),
        .hsync       (hsync),
        .vsync       (vsync),
        .vblank      (vblank),
        .frame_pulse (frame_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] vram_word(input logic [14:0] a);
        case (a)
            15'h3000: vram_word = 32'h0F41_0F42;
            15'h3001: vram_word = 32'h2143_1244;
            15'h3002: vram_word = 32'h0F41_0F41;
            15'h3004: vram_word = 32'h0F20_0F20;
            15'h3005: vram_word = 32'h0F20_0F20;
            default:  vram_word = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [7:0] font_byte(input logic [10:0] a);
        case (a)
            11'h208: font_byte = 8'h01;
            11'h210: font_byte = 8'hFF;
            11'h218: font_byte = 8'h0F;
            default: font_byte = 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        vram_data <= vram_word(vram_addr);
        font_data <= font_byte(font_addr);
    end

    // frame_pulse period and width in clocks
    int clk_n    = 0;
    int last_fp  = -1;
    int fp_per   = 0;
    int fp_run   = 0;
    int fp_width = 0;
    always @(negedge clk) begin
        clk_n = clk_n + 1;
        if (frame_pulse) begin
            fp_run = fp_run + 1;
            if (fp_run == 1) begin
                if (last_fp >= 0) fp_per = clk_n - last_fp;
                last_fp = clk_n;
            end
        end else begin
            if (fp_run != 0) fp_width = fp_run;
            fp_run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h (pix %0d)", tag, got, exp, cnt);
        end
    endtask

    task automatic step();
        @(negedge clk);
        pix_ce = 1'b1;
        @(negedge clk);
        pix_ce = 1'b0;
        cnt = cnt + 1;
    endtask

    task automatic step_to(input int n);
        while (cnt < n) step();
    endtask

    task automatic step_pal(input logic [3:0] idx, input logic [7:0] data);
        @(negedge clk);
        pix_ce   = 1'b1;
        pal_we   = 1'b1;
        pal_idx  = idx;
        pal_data = data;
        @(negedge clk);
        pix_ce   = 1'b0;
        pal_we   = 1'b0;
        cnt = cnt + 1;
    endtask

    task automatic pal_write(input logic [3:0] idx, input logic [7:0] data);
        @(negedge clk);
        pal_we   = 1'b1;
        pal_idx  = idx;
        pal_data = data;
        @(negedge clk);
        pal_we   = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // after cnt pix_ce pulses: vram_addr shows pixel cnt-1, rgb/syncs pixel cnt-3
    initial begin
        rst        = 1'b1;
        pix_ce     = 1'b0;
        pal_we     = 1'b0;
        pal_idx    = 4'd0;
        pal_data   = 8'h00;
        scroll_row = 6'd0;
        cursor_en  = 1'b1;
        cursor_col = 7'd1;
        cursor_row = 6'd2;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rgb",    32'(rgb),         32'h00);
        check("rst_hsync",  32'(hsync),       32'h1);
        check("rst_vsync",  32'(vsync),       32'h1);
        check("rst_vblank", 32'(vblank),      32'h0);
        check("rst_fp",     32'(frame_pulse), 32'h0);

        pal_write(4'd1, 8'h1C);
        pal_write(4'd2, 8'h03);

        step();      check("addr_px0",        32'(vram_addr), 32'h3000);
        step();      check("partial_rgb",     32'(rgb),       32'h00);
                     check("partial_hsync",   32'(hsync),     32'h1);
        step();      check("px0_fg",          32'(rgb),       32'hFF);
        step();      check("px1_bg",          32'(rgb),       32'h00);
        step_to(11); check("px8_fg",          32'(rgb),       32'hFF);
        step_pal(4'd15, 8'hE0);
                     check("pal_same_edge",   32'(rgb),       32'hFF);
        step();      check("pal_new",         32'(rgb),       32'hE0);
        step_to(19); check("px16_fg_pal1",    32'(rgb),       32'h1C);
        step_to(23); check("px20_bg_pal2",    32'(rgb),       32'h03);
        step_to(35); check("px32_blank",      32'(rgb),       32'h00);
        step_to(36); check("hs_before",       32'(hsync),     32'h1);
        step_to(37); check("hs_first",        32'(hsync),     32'h0);
        step_to(40); check("hs_last",         32'(hsync),     32'h0);
        step_to(41); check("hs_after",        32'(hsync),     32'h1);
        step_to(891); check("cur_off_f0",     32'(rgb),       32'h00);
        step_to(1279); check("vblank_lo",     32'(vblank),    32'h0);
        step_to(1280); check("vblank_hi",     32'(vblank),    32'h1);
        step_to(1300); scroll_row = 6'd3;
        step_to(1322); check("vs_before",     32'(vsync),     32'h1);
        step_to(1323); check("vs_first",      32'(vsync),     32'h0);
        step_to(1439); check("fp_low",        32'(frame_pulse), 32'h0);
        step_to(1440); check("fp_high",       32'(frame_pulse), 32'h1);
        step_to(1441); check("scroll_row0",   32'(vram_addr), 32'h3006);
                       check("fp_width",      32'(fp_width),  32'd1);
        step_to(1465); check("scroll_row0c3", 32'(vram_addr), 32'h3007);
        step_to(1761); check("scroll_wrap",   32'(vram_addr), 32'h3000);
        step_to(2331); check("cur_off_f1",    32'(rgb),       32'h00);
        step_to(2401); check("scroll_row3",   32'(vram_addr), 32'h3004);
        step_to(2800); scroll_row = 6'd0;
        step_to(2881); check("fp_period",     32'(fp_per),    32'd2880);
        step_to(3731); check("cur_line5",     32'(rgb),       32'h00);
        step_to(3771); check("cur_on_l6",     32'(rgb),       32'hE0);
        step_to(3779); check("cur_next_col",  32'(rgb),       32'h00);
        step_to(3818); check("cur_on_l7",     32'(rgb),       32'hE0);
        step_to(4330); cursor_en = 1'b0;
        step_to(5211); check("cur_disabled",  32'(rgb),       32'h00);
        step_to(5678); check("pre_rst_hs",    32'(hsync),     32'h0);
                       check("pre_rst_vs",    32'(vsync),     32'h0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        check("mrst_rgb",    32'(rgb),         32'h00);
        check("mrst_hsync",  32'(hsync),       32'h1);
        check("mrst_vsync",  32'(vsync),       32'h1);
        check("mrst_vblank", 32'(vblank),      32'h0);
        step();  check("mrst_addr",    32'(vram_addr), 32'h3000);
        step();  check("mrst_partial", 32'(rgb),       32'h00);
        step();  check("mrst_px0",     32'(rgb),       32'hFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
